// File: rtl/id_ex_skid.sv
// id_ex_skid: ID/EX pipeline register with a valid/ready handshake,
// a two-entry skid buffer and a synchronous flush.
//
// The main entry M drives ex_*. The skid entry S catches the one beat
// that ID may hand over in the cycle EX stalls. Because id_ready is taken
// from a flop, no combinational path runs from ex_ready back to ID.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   flush      synchronous squash of the held beats and the incoming beat
//   id_valid   ID presents an instruction
//   id_ready   the buffer can accept (registered: !S.valid)
//   id_*       decoded payload: aluop, alusel, reg1, reg2, wd, wreg
//   ex_valid   EX-side instruction present (M.valid)
//   ex_ready   EX consumes the presented instruction
//   ex_*       presented payload; all zero while M is empty
module id_ex_skid #(
  parameter int ALUOP_W   = 8,
  parameter int ALUSEL_W  = 3,
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [ALUOP_W-1:0]   id_aluop,
  input  logic [ALUSEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0]    id_reg1,
  input  logic [DATA_W-1:0]    id_reg2,
  input  logic [REGADDR_W-1:0] id_wd,
  input  logic                 id_wreg,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [ALUOP_W-1:0]   ex_aluop,
  output logic [ALUSEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0]    ex_reg1,
  output logic [DATA_W-1:0]    ex_reg2,
  output logic [REGADDR_W-1:0] ex_wd,
  output logic                 ex_wreg
);

  typedef struct packed {
    logic [ALUOP_W-1:0]   aluop;
    logic [ALUSEL_W-1:0]  alusel;
    logic [DATA_W-1:0]    reg1;
    logic [DATA_W-1:0]    reg2;
    logic [REGADDR_W-1:0] wd;
    logic                 wreg;
  } payload_t;

  logic     m_vld_q, m_vld_d;
  logic     s_vld_q, s_vld_d;
  payload_t m_q, m_d;
  payload_t s_q, s_d;
  payload_t in_pl;
  logic     acc, con;

  assign in_pl = '{aluop: id_aluop, alusel: id_alusel, reg1: id_reg1,
                   reg2: id_reg2, wd: id_wd, wreg: id_wreg};

  assign acc = id_valid & ~s_vld_q;
  assign con = m_vld_q & ex_ready;

  // An empty entry always carries an all-zero payload, so ex_* read
  // straight from M show NOP values with no output gating.
  always_comb begin
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      // A consume in this cycle has already been seen by EX; a beat
      // accepted in this cycle is dropped.
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
      m_d     = '0;
      s_d     = '0;
    end else if (!m_vld_q) begin
      // S is never full while M is empty.
      if (acc) begin
        m_vld_d = 1'b1;
        m_d     = in_pl;
      end
    end else if (con) begin
      if (s_vld_q) begin
        m_d     = s_q;
        s_vld_d = 1'b0;
        s_d     = '0;
      end else if (acc) begin
        m_d     = in_pl;
      end else begin
        m_vld_d = 1'b0;
        m_d     = '0;
      end
    end else if (acc) begin
      // EX is stalled: park the beat in S. id_ready drops next cycle.
      s_vld_d = 1'b1;
      s_d     = in_pl;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign id_ready  = ~s_vld_q;
  assign ex_valid  = m_vld_q;
  assign ex_aluop  = m_q.aluop;
  assign ex_alusel = m_q.alusel;
  assign ex_reg1   = m_q.reg1;
  assign ex_reg2   = m_q.reg2;
  assign ex_wd     = m_q.wd;
  assign ex_wreg   = m_q.wreg;

endmodule

// File: tb/tb_id_ex_skid.sv
// tb_id_ex_skid: self-checking bench for id_ex_skid. It runs directed
// scenarios and a randomized run against a queue model of a 2-deep FIFO
// with flush. A second instance covers 64-bit operands and 6-bit
// register addresses.
module tb_id_ex_skid;

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } pl_t;

  logic clk, rst, flush, id_valid, ex_ready;
  pl_t  din;
  logic        id_ready, ex_valid, ex_wreg;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0]  ex_wd;

  // wide instance signals
  logic        w_flush, w_id_valid, w_id_ready, w_ex_valid, w_ex_ready;
  logic [7:0]  w_id_aluop, w_ex_aluop;
  logic [2:0]  w_id_alusel, w_ex_alusel;
  logic [63:0] w_id_reg1, w_id_reg2, w_ex_reg1, w_ex_reg2;
  logic [5:0]  w_id_wd, w_ex_wd;
  logic        w_id_wreg, w_ex_wreg;

  int cmp_cnt = 0;
  int err_cnt = 0;
  pl_t q[$];

  id_ex_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(din.aluop), .id_alusel(din.alusel), .id_reg1(din.reg1),
    .id_reg2(din.reg2), .id_wd(din.wd), .id_wreg(din.wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
    .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg)
  );

  id_ex_skid #(.DATA_W(64), .REGADDR_W(6)) u_wide (
    .clk(clk), .rst(rst), .flush(w_flush),
    .id_valid(w_id_valid), .id_ready(w_id_ready),
    .id_aluop(w_id_aluop), .id_alusel(w_id_alusel), .id_reg1(w_id_reg1),
    .id_reg2(w_id_reg2), .id_wd(w_id_wd), .id_wreg(w_id_wreg),
    .ex_valid(w_ex_valid), .ex_ready(w_ex_ready),
    .ex_aluop(w_ex_aluop), .ex_alusel(w_ex_alusel), .ex_reg1(w_ex_reg1),
    .ex_reg2(w_ex_reg2), .ex_wd(w_ex_wd), .ex_wreg(w_ex_wreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic pl_t rnd_pl();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[80:0];
  endfunction

  // Compare every DUT output with the model's view of the FIFO head.
  task automatic chk_all(input string tag);
    pl_t exp;
    exp = (q.size() != 0) ? q[0] : '0;
    chk({tag, ":ex_valid"}, 128'(ex_valid), 128'(q.size() != 0));
    chk({tag, ":id_ready"}, 128'(id_ready), 128'(q.size() < 2));
    chk({tag, ":ex_payload"},
        128'({ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg}), 128'(exp));
  endtask

  // One clock: the model steps on the same inputs the DUT sees at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic cycle(input string tag);
    bit acc, con;
    @(posedge clk);
    acc = id_valid && (q.size() < 2);
    con = ex_ready && (q.size() != 0);
    if (flush) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(din);
    end
    #1;
    chk_all(tag);
  endtask

  pl_t a, b;

  initial begin
    rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0; din = '0;
    w_flush = 1'b0; w_id_valid = 1'b0; w_ex_ready = 1'b0;
    w_id_aluop = '0; w_id_alusel = '0; w_id_reg1 = '0; w_id_reg2 = '0;
    w_id_wd = '0; w_id_wreg = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset_w_ready", 128'(w_id_ready), 128'(1));
    #2 rst = 1'b1;

    // streaming
    ex_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din = rnd_pl(); din.reg1 = i; id_valid = 1'b1;
      cycle("stream");
      chk("stream_reg1", 128'(ex_reg1), 128'(i));
      chk("stream_ready", 128'(id_ready), 128'(1));
    end
    id_valid = 1'b0;
    cycle("stream_drain");

    // stall into skid
    a = rnd_pl(); b = rnd_pl();
    din = a; id_valid = 1'b1; ex_ready = 1'b0;
    cycle("stall_a");
    din = b;
    cycle("stall_b");
    chk("stall_ready0", 128'(id_ready), 128'(0));
    chk("stall_hold_a", 128'(ex_reg1), 128'(a.reg1));
    id_valid = 1'b0; ex_ready = 1'b1;
    cycle("stall_drain");
    chk("stall_b_pres", 128'(ex_reg1), 128'(b.reg1));
    chk("stall_refill", 128'(id_ready), 128'(1));
    cycle("stall_empty");

    // flush with M and S full and a consume in the same cycle
    ex_ready = 1'b0; id_valid = 1'b1;
    din = rnd_pl(); cycle("fl_a");
    din = rnd_pl(); cycle("fl_b");
    id_valid = 1'b0; flush = 1'b1; ex_ready = 1'b1;
    cycle("fl_go");
    chk("flush_empty", 128'(ex_valid), 128'(0));
    flush = 1'b0;
    cycle("fl_after");
    // flush during accept of C with M empty
    din = rnd_pl(); id_valid = 1'b1; flush = 1'b1;
    cycle("fl_c");
    id_valid = 1'b0; flush = 1'b0;
    cycle("fl_c_after");
    chk("flush_c_gone", 128'(ex_valid), 128'(0));

    // wreg gating
    din = rnd_pl(); din.wreg = 1'b1; din.wd = 5'd31; id_valid = 1'b1; ex_ready = 1'b0;
    cycle("wreg_load");
    chk("wreg_pres", 128'(ex_wreg), 128'(1));
    id_valid = 1'b0; ex_ready = 1'b1;
    cycle("wreg_con");
    chk("wreg_gate", 128'(ex_wreg), 128'(0));
    chk("wd_gate", 128'(ex_wd), 128'(0));

    // randomized run
    for (int i = 0; i < 400; i++) begin
      din      = rnd_pl();
      id_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end
    flush = 1'b0;

    // reset mid-stream with M and S full
    ex_ready = 1'b0; id_valid = 1'b1;
    din = rnd_pl(); cycle("mr_a");
    din = rnd_pl(); cycle("mr_b");
    chk("mr_full", 128'(id_ready), 128'(0));
    id_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    chk_all("mr_async");
    #2 rst = 1'b1;
    din = '0; din.aluop = 8'h21; din.wd = 5'd5; id_valid = 1'b1;
    cycle("mr_first");
    chk("mr_aluop", 128'(ex_aluop), 128'(8'h21));
    chk("mr_wd", 128'(ex_wd), 128'(5));
    id_valid = 1'b0; ex_ready = 1'b1;
    cycle("mr_drain");

    // wide instance: both entries carry the wide values
    w_id_reg2 = 64'hFFFF_FFFF_0000_0001; w_id_wd = 6'd63; w_id_wreg = 1'b1;
    w_id_reg1 = 64'h8000_0000_0000_0003;
    w_id_aluop = 8'hA5; w_id_valid = 1'b1;
    @(posedge clk); #1;
    w_id_aluop = 8'h5A;
    @(posedge clk); #1;
    w_id_valid = 1'b0;
    chk("w_m_reg2", 128'(w_ex_reg2), 128'(64'hFFFF_FFFF_0000_0001));
    chk("w_m_wd", 128'(w_ex_wd), 128'(63));
    chk("w_m_aluop", 128'(w_ex_aluop), 128'(8'hA5));
    chk("w_s_full", 128'(w_id_ready), 128'(0));
    w_ex_ready = 1'b1;
    @(posedge clk); #1;
    chk("w_s_reg2", 128'(w_ex_reg2), 128'(64'hFFFF_FFFF_0000_0001));
    chk("w_s_reg1", 128'(w_ex_reg1), 128'(64'h8000_0000_0000_0003));
    chk("w_s_wd", 128'(w_ex_wd), 128'(63));
    chk("w_s_aluop", 128'(w_ex_aluop), 128'(8'h5A));
    @(posedge clk); #1;
    chk("w_empty", 128'(w_ex_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
